// File: rtl/mp_fifo_enq_alloc.sv
`default_nettype none
// ============================================================================
// Module   : mp_fifo_enq_alloc
// Brief    : Round-robin, credit-gated enqueue allocator that packs granted
//            requests onto the lanes of a multi-port FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mp_fifo_enq_alloc #(
    parameter int NUM_REQ        = 8,
    parameter int ENQ_WIDTH      = 4,
    parameter int DEQ_WIDTH      = 4,
    parameter int DEPTH          = 16,
    parameter int PAYLOAD_WIDTH  = 32,
    parameter int MUST_TAKEN_ALL = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_vld_i,
    input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0]   req_payload_i,
    output logic [NUM_REQ-1:0]                 req_rdy_o,
    output logic [ENQ_WIDTH-1:0]               fifo_enq_vld_o,
    output logic [ENQ_WIDTH*PAYLOAD_WIDTH-1:0] fifo_enq_payload_o,
    input  logic [$clog2(DEQ_WIDTH+1)-1:0]     deq_cnt_i,
    input  logic                               flush_i,
    output logic [$clog2(DEPTH+1)-1:0]         credit_o
);

    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam int              c_PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ENQ   = c_CW'(ENQ_WIDTH);
    localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

    logic [c_CW-1:0]          r_credit;
    logic [c_PW-1:0]          r_rr_ptr;
    logic [c_CW-1:0]          w_allow;
    logic [c_CW-1:0]          w_cnt;
    logic [c_PW-1:0]          w_idx;
    logic [c_PW-1:0]          w_next_ptr;
    logic [PAYLOAD_WIDTH-1:0] w_req_pl  [NUM_REQ];
    logic [PAYLOAD_WIDTH-1:0] w_lane_pl [ENQ_WIDTH];

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_req_split
            assign w_req_pl[g] = req_payload_i[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        end
        for (genvar g = 0; g < ENQ_WIDTH; g++) begin : g_lane_pack
            assign fifo_enq_payload_o[g*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] = w_lane_pl[g];
        end
    endgenerate

    // All-or-nothing mode only opens the lanes when a full-width enqueue fits.
    always_comb begin
        w_allow = '0;
        if (flush_i) begin
            w_allow = '0;
        end else if (MUST_TAKEN_ALL != 0) begin
            w_allow = (r_credit >= c_ENQ) ? c_ENQ : '0;
        end else begin
            w_allow = (r_credit >= c_ENQ) ? c_ENQ : r_credit;
        end
    end

    always_comb begin
        req_rdy_o      = '0;
        fifo_enq_vld_o = '0;
        w_cnt          = '0;
        w_idx          = '0;
        w_next_ptr     = r_rr_ptr;
        for (int l = 0; l < ENQ_WIDTH; l++) begin
            w_lane_pl[l] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = c_PW'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (req_vld_i[w_idx] && (w_cnt < w_allow)) begin
                req_rdy_o[w_idx] = 1'b1;
                for (int l = 0; l < ENQ_WIDTH; l++) begin
                    if (w_cnt == c_CW'(l)) begin
                        fifo_enq_vld_o[l] = 1'b1;
                        w_lane_pl[l]      = w_req_pl[w_idx];
                    end
                end
                w_cnt      = w_cnt + c_ONE;
                w_next_ptr = c_PW'((int'(w_idx) + 1) % NUM_REQ);
            end
        end
    end

    // Dequeue returns become visible next cycle; flush drops everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit <= c_DEPTH;
            r_rr_ptr <= '0;
        end else if (flush_i) begin
            r_credit <= c_DEPTH;
            r_rr_ptr <= '0;
        end else begin
            r_credit <= r_credit - w_cnt + c_CW'(deq_cnt_i);
            r_rr_ptr <= w_next_ptr;
        end
    end

    assign credit_o = r_credit;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && !flush_i) begin
            assert (c_CW'(deq_cnt_i) <= (c_DEPTH - r_credit))
                else $error("deq_cnt_i exceeds occupied entries");
        end
        if (rst) begin
            assert (r_credit <= c_DEPTH)
                else $error("credit out of range");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_fifo_enq_alloc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_fifo_enq_alloc
// Brief    : Directed scoreboard bench for mp_fifo_enq_alloc in both grant modes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_fifo_enq_alloc;

    localparam int NR = 8;
    localparam int EW = 4;
    localparam int PW = 32;

    logic               clk;
    logic               rst;
    logic [NR*PW-1:0]   req_payload;
    logic [NR-1:0]      vld0, vld1, rdy0, rdy1;
    logic [2:0]         deq0, deq1;
    logic               fl0, fl1;
    logic [EW-1:0]      lv0, lv1;
    logic [EW*PW-1:0]   lp0, lp1;
    logic [4:0]         cr0, cr1;

    mp_fifo_enq_alloc #(.NUM_REQ(NR), .ENQ_WIDTH(EW), .DEQ_WIDTH(4), .DEPTH(16),
                        .PAYLOAD_WIDTH(PW), .MUST_TAKEN_ALL(0)) u_dut0 (
        .clk(clk), .rst(rst), .req_vld_i(vld0), .req_payload_i(req_payload),
        .req_rdy_o(rdy0), .fifo_enq_vld_o(lv0), .fifo_enq_payload_o(lp0),
        .deq_cnt_i(deq0), .flush_i(fl0), .credit_o(cr0));

    mp_fifo_enq_alloc #(.NUM_REQ(NR), .ENQ_WIDTH(EW), .DEQ_WIDTH(4), .DEPTH(16),
                        .PAYLOAD_WIDTH(PW), .MUST_TAKEN_ALL(1)) u_dut1 (
        .clk(clk), .rst(rst), .req_vld_i(vld1), .req_payload_i(req_payload),
        .req_rdy_o(rdy1), .fifo_enq_vld_o(lv1), .fifo_enq_payload_o(lp1),
        .deq_cnt_i(deq1), .flush_i(fl1), .credit_o(cr1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // lanes: one nibble per lane (lane0 in bits 3:0), value = requester index, F = idle
    typedef struct {
        logic        sel;
        logic [7:0]  rdy;
        logic [15:0] lanes;
        logic [4:0]  cr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic cyc(input logic r, input logic sel, input logic [7:0] v,
                       input logic [2:0] d, input logic f, input logic [7:0] rdy,
                       input logic [15:0] lanes, input logic [4:0] cr);
        exp_t x;
        @(posedge clk);
        #1;
        rst  = r;
        vld0 = sel ? 8'h00 : v;
        deq0 = sel ? 3'd0  : d;
        fl0  = sel ? 1'b0  : f;
        vld1 = sel ? v     : 8'h00;
        deq1 = sel ? d     : 3'd0;
        fl1  = sel ? f     : 1'b0;
        x.sel = sel; x.rdy = rdy; x.lanes = lanes; x.cr = cr;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            logic [7:0]     g_rdy;
            logic [EW-1:0]  g_lv, x_lv;
            logic [EW*PW-1:0] g_lp, x_lp;
            logic [4:0]     g_cr;
            logic [3:0]     n;
            e     = q.pop_front();
            g_rdy = e.sel ? rdy1 : rdy0;
            g_lv  = e.sel ? lv1  : lv0;
            g_lp  = e.sel ? lp1  : lp0;
            g_cr  = e.sel ? cr1  : cr0;
            x_lv  = '0;
            x_lp  = '0;
            for (int l = 0; l < EW; l++) begin
                n = e.lanes[l*4 +: 4];
                if (n != 4'hF) begin
                    x_lv[l]        = 1'b1;
                    x_lp[l*PW +: PW] = 32'hC0DE_0000 + 32'(n);
                end
            end
            checks++;
            if (g_rdy !== e.rdy) begin
                errors++;
                $display("FAIL rdy dut%0d t=%0t got %h want %h", e.sel, $time, g_rdy, e.rdy);
            end
            checks++;
            if (g_lv !== x_lv || g_lp !== x_lp) begin
                errors++;
                $display("FAIL lanes dut%0d t=%0t got vld %h pl %h want vld %h pl %h",
                         e.sel, $time, g_lv, g_lp, x_lv, x_lp);
            end
            checks++;
            if (g_cr !== e.cr) begin
                errors++;
                $display("FAIL credit dut%0d t=%0t got %0d want %0d", e.sel, $time, g_cr, e.cr);
            end
        end
    end

    initial begin
        rst = 1'b1;
        vld0 = '0; vld1 = '0; deq0 = '0; deq1 = '0; fl0 = 1'b0; fl1 = 1'b0;
        for (int i = 0; i < NR; i++) req_payload[i*PW +: PW] = 32'hC0DE_0000 + 32'(i);
        #2 rst = 1'b0;

        // reset state, both modes
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 16'hFFFF, 16);
        cyc(0, 1, 8'h00, 0, 0, 8'h00, 16'hFFFF, 16);

        // all valid from reset: alternating halves until credit runs out
        cyc(1, 0, 8'hFF, 0, 0, 8'h0F, 16'h3210, 16);
        cyc(1, 0, 8'hFF, 0, 0, 8'hF0, 16'h7654, 12);
        cyc(1, 0, 8'hFF, 0, 0, 8'h0F, 16'h3210, 8);
        cyc(1, 0, 8'hFF, 0, 0, 8'hF0, 16'h7654, 4);
        cyc(1, 0, 8'hFF, 0, 0, 8'h00, 16'hFFFF, 0);
        // return 2 credits, then partial grant of 1,3 (not 5)
        cyc(1, 0, 8'h00, 2, 0, 8'h00, 16'hFFFF, 0);
        cyc(1, 0, 8'h2A, 0, 0, 8'h0A, 16'hFF31, 2);
        // credit 0 with a dequeue: no same-cycle bypass, then 3 grants from rr 4
        cyc(1, 0, 8'hFF, 3, 0, 8'h00, 16'hFFFF, 0);
        cyc(1, 0, 8'hFF, 0, 0, 8'h70, 16'hF654, 3);
        // build credit 5, then flush with pending dequeue
        cyc(1, 0, 8'h00, 4, 0, 8'h00, 16'hFFFF, 0);
        cyc(1, 0, 8'h00, 1, 0, 8'h00, 16'hFFFF, 4);
        cyc(1, 0, 8'hFF, 2, 1, 8'h00, 16'hFFFF, 5);
        // flush restored credit 16 and pointer 0 (order 0 then 7)
        cyc(1, 0, 8'h81, 0, 0, 8'h81, 16'hFF70, 16);
        cyc(1, 0, 8'h20, 2, 0, 8'h20, 16'hFFF5, 14);
        cyc(1, 0, 8'h00, 1, 0, 8'h00, 16'hFFFF, 15);
        // pointer 6: wraparound 7,0,2
        cyc(1, 0, 8'h85, 0, 0, 8'h85, 16'hF207, 16);
        cyc(1, 0, 8'h00, 0, 0, 8'h00, 16'hFFFF, 13);
        cyc(1, 0, 8'hFF, 0, 0, 8'h78, 16'h6543, 13);
        cyc(1, 0, 8'h03, 0, 0, 8'h03, 16'hFF10, 9);
        // credit 7, pointer 2: asynchronous reset mid-cycle
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 16'hFFFF, 16);
        cyc(0, 0, 8'h00, 0, 0, 8'h00, 16'hFFFF, 16);
        cyc(1, 0, 8'hFF, 0, 0, 8'h0F, 16'h3210, 16);

        // all-or-nothing mode
        cyc(1, 1, 8'hFF, 0, 0, 8'h0F, 16'h3210, 16);
        cyc(1, 1, 8'hFF, 0, 0, 8'hF0, 16'h7654, 12);
        cyc(1, 1, 8'hFF, 0, 0, 8'h0F, 16'h3210, 8);
        cyc(1, 1, 8'hFF, 0, 0, 8'hF0, 16'h7654, 4);
        cyc(1, 1, 8'h00, 2, 0, 8'h00, 16'hFFFF, 0);
        cyc(1, 1, 8'h2A, 0, 0, 8'h00, 16'hFFFF, 2);
        cyc(1, 1, 8'h2A, 2, 0, 8'h00, 16'hFFFF, 2);
        cyc(1, 1, 8'h2A, 0, 0, 8'h2A, 16'hF531, 4);
        cyc(1, 1, 8'h2A, 0, 0, 8'h00, 16'hFFFF, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mp_fifo_enq_alloc.md
Name: mp_fifo_enq_alloc

Overview:
Credit-based enqueue allocator placed in front of a multi-port FIFO with ENQ_WIDTH enqueue lanes. It shares those lanes among NUM_REQ requesters using rotating (round-robin) priority. Granted requests are packed onto FIFO lanes 0..k-1. A local credit counter mirrors the FIFO's free-entry count, so the allocator never overfills the FIFO and never needs a same-cycle ready from it.

Parameters:
NUM_REQ, 8, number of requesters.
ENQ_WIDTH, 4, FIFO enqueue lanes; must be <= NUM_REQ.
DEQ_WIDTH, 4, FIFO dequeue lanes; sizes deq_cnt_i.
DEPTH, 16, FIFO entry count; initial and maximum credit.
PAYLOAD_WIDTH, 32, payload bits per request.
MUST_TAKEN_ALL, 1, if 1 grant only when credit >= ENQ_WIDTH (matches FIFO all-or-nothing mode).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-low.
req_vld_i  input  NUM_REQ  request valid per requester.
req_payload_i  input  NUM_REQ x PAYLOAD_WIDTH  request payloads.
req_rdy_o  output  NUM_REQ  grant; a request fires when vld & rdy.
fifo_enq_vld_o  output  ENQ_WIDTH  FIFO lane valid.
fifo_enq_payload_o  output  ENQ_WIDTH x PAYLOAD_WIDTH  FIFO lane payload.
deq_cnt_i  input  clog2(DEQ_WIDTH+1)  FIFO dequeue fires this cycle.
flush_i  input  1  synchronous flush, tied to the FIFO flush.
credit_o  output  clog2(DEPTH+1)  current registered credit.

Behaviour:
- State: credit register, width clog2(DEPTH+1); rr_ptr register, width clog2(NUM_REQ).
- Reset (rst low, asynchronous): credit = DEPTH, rr_ptr = 0, immediately. With no requests, req_rdy_o = 0, fifo_enq_vld_o = 0, fifo_enq_payload_o = 0, credit_o = DEPTH.
- Allowance N_allow:
  - MUST_TAKEN_ALL=0: min(credit, ENQ_WIDTH).
  - MUST_TAKEN_ALL=1: ENQ_WIDTH if credit >= ENQ_WIDTH, else 0.
  - Forced to 0 while flush_i = 1.
- Grant is combinational, with zero-cycle latency from req_vld_i:
  - Scan requesters from rr_ptr upward, modulo NUM_REQ.
  - Grant the first N_allow with req_vld_i = 1.
  - The k-th grant in scan order drives lane k: fifo_enq_vld_o[k] = 1, fifo_enq_payload_o[k] = its payload.
  - Lanes are always contiguous from lane 0.
  - Unused lanes: vld = 0, payload = 0.
  - req_rdy_o[i] = 1 only for granted i, never for an invalid requester.
  - Under MUST_TAKEN_ALL=1, fewer than ENQ_WIDTH valid requesters may still be granted when credit >= ENQ_WIDTH.
- Credit update each clock:
  - flush_i = 1: credit <= DEPTH. deq_cnt_i is ignored.
  - Otherwise: credit <= credit - grant_cnt + deq_cnt_i.
  - Credits returned by deq_cnt_i become usable the next cycle; there is no same-cycle bypass.
- rr_ptr update:
  - At least one grant: rr_ptr <= (index of last granted requester + 1) mod NUM_REQ.
  - No grant: unchanged.
  - flush_i = 1: rr_ptr <= 0.
- Illegal conditions (checked by assertion, design behaviour unspecified):
  - deq_cnt_i > DEPTH - credit.
  - credit leaving 0..DEPTH.
- Boundaries:
  - credit = 0: no grants.
  - credit = DEPTH with deq_cnt_i = 0: legal.
  - Simultaneous grant and dequeue use the net update above.
  - Reset asserted mid-cycle overrides all pending updates.

Test Plan:
1. MUST_TAKEN_ALL=0, all 8 requesters valid continuously from reset, deq_cnt_i=0.
   -> Cycles 1-4 grant reqs 0-3, 4-7, 0-3, 4-7 on lanes 0-3.
   -> credit_o reads 16, 12, 8, 4, 0.
   -> Cycle 5: no grants, rr_ptr stays 0.
2. credit=2, requesters 1,3,5 valid, rr_ptr=0.
   -> MUST_TAKEN_ALL=0: lane0=req1, lane1=req3, req5 not granted, credit 0, rr_ptr 4.
   -> MUST_TAKEN_ALL=1: no grants, credit stays 2.
3. credit=0, requesters valid, deq_cnt_i=3.
   -> No grant that cycle, credit_o=3 next cycle.
   -> Then MUST_TAKEN_ALL=0 grants 3 requesters.
4. rr_ptr=6, requesters 7,0,2 valid, credit=16.
   -> lane0=req7, lane1=req0, lane2=req2, lane3 invalid, payload 0.
   -> Next cycle credit 13, rr_ptr 3.
5. credit=5, all requesters valid, flush_i=1, deq_cnt_i=2.
   -> req_rdy_o=0, fifo_enq_vld_o=0.
   -> Next cycle credit_o=16, rr_ptr=0.
6. credit=7, rst driven low between clock edges.
   -> credit_o=16 and rr_ptr=0 before the next edge.
   -> No grants while rst is low with req_vld_i=0.
